// File: rtl/ex_md_engine.sv
// Multiply/divide unit for the EX stage: HI/LO registers, a fixed-latency multiplier and a radix-2 restoring divider.
// Mul/div stall the pipeline until the result is written (1+MUL_LAT, 1+W, or 1 cycle); flush aborts without writing.
module ex_md_engine #(
  parameter int W       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   op,
  input  logic [W-1:0] rs_data,
  input  logic [W-1:0] rt_data,
  input  logic         flush,
  output logic [W-1:0] md_data,
  output logic         stall,
  output logic         busy,
  output logic         div0
);
  localparam int CMAX = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [W-1:0]  hi, lo;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_sgn;
  logic [W-1:0]  quo, rem, dvs;
  logic          neg_q, neg_r;

  logic           md_op, rt_zero;
  logic [W-1:0]   rs_abs, rt_abs;
  logic [2*W-1:0] prod;
  logic [W:0]     shifted;
  logic [W-1:0]   diff, rem_nx, quo_nx, quo_fin, rem_fin;
  logic           ge;

  assign md_op   = |op[7:4];
  assign rt_zero = (rt_data == '0);
  // Only signed div takes magnitudes; op[7] wins the priority so it alone selects this.
  assign rs_abs  = (op[7] && rs_data[W-1]) ? -rs_data : rs_data;
  assign rt_abs  = (op[7] && rt_data[W-1]) ? -rt_data : rt_data;

  // Extending both operands to 2W bits makes the low 2W product bits exact for signed and unsigned alike.
  assign prod = {{W{mul_sgn & mul_a[W-1]}}, mul_a} * {{W{mul_sgn & mul_b[W-1]}}, mul_b};

  assign shifted = {rem, quo[W-1]};
  assign ge      = shifted >= {1'b0, dvs};
  assign diff    = shifted[W-1:0] - dvs;
  assign rem_nx  = ge ? diff : shifted[W-1:0];
  assign quo_nx  = {quo[W-2:0], ge};
  assign quo_fin = neg_q ? -quo_nx : quo_nx;
  assign rem_fin = neg_r ? -rem_nx : rem_nx;

  assign md_data = op[3] ? hi : (op[2] ? lo : '0);
  assign busy    = (state == MUL) || (state == DIV);
  assign stall   = !flush && (busy || (state == IDLE && md_op));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      div0    <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      div0 <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (op[7] || op[6]) begin
              if (rt_zero) begin
                hi    <= rs_data;
                lo    <= '1;
                div0  <= 1'b1;
                state <= DONE;
              end else begin
                quo   <= rs_abs;
                rem   <= '0;
                dvs   <= rt_abs;
                neg_q <= op[7] && (rs_data[W-1] ^ rt_data[W-1]);
                neg_r <= op[7] && rs_data[W-1];
                state <= DIV;
              end
            end else if (op[5] || op[4]) begin
              mul_a   <= rs_data;
              mul_b   <= rt_data;
              mul_sgn <= op[5];
              state   <= MUL;
            end else if (op[1]) begin
              hi <= rs_data;
            end else if (op[0]) begin
              lo <= rs_data;
            end
          end
          MUL: begin
            if (cnt == CW'(MUL_LAT - 1)) begin
              {hi, lo} <= prod;
              cnt      <= '0;
              state    <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DIV: begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (cnt == CW'(W - 1)) begin
              hi    <= rem_fin;
              lo    <= quo_fin;
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_md_engine.sv
// Scoreboarded bench for ex_md_engine: directed corner cases plus random ops against a longint arithmetic model.
module tb_ex_md_engine;
  localparam int W  = 32;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [7:0]  op;
  logic [31:0] rs, rt, md_data;
  logic        stall, busy, div0;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m, lo_m;
  logic [31:0] sb[$];

  ex_md_engine #(.W(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .op(op), .rs_data(rs), .rt_data(rt), .flush(flush),
    .md_data(md_data), .stall(stall), .busy(busy), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: any cycle presenting mfhi/mflo is a DUT output to score.
  always @(negedge clk) begin
    if (!rst && (op[3] || op[2])) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got %h expected none", md_data);
      end else begin
        chk("md_data", md_data, sb.pop_front());
      end
    end
  end

  // Reference model: plain 64-bit arithmetic, priority decode as architected.
  task automatic model(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int est, output int ed0);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    est = 0;
    ed0 = 0;
    if (o[7] || o[6]) begin
      if (b == 0) begin
        hi_m = a; lo_m = 32'hFFFF_FFFF; est = 1; ed0 = 1;
      end else begin
        if (o[7]) begin
          q = sa / sbv; r = sa % sbv;
        end else begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
        end
        lo_m = q[31:0]; hi_m = r[31:0]; est = 1 + W;
      end
    end else if (o[5]) begin
      p = 64'(sa * sbv); {hi_m, lo_m} = p; est = 1 + ML;
    end else if (o[4]) begin
      p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = p; est = 1 + ML;
    end else if (o[1]) begin
      hi_m = a;
    end else if (o[0]) begin
      lo_m = a;
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    int est, ed0, st, d0;
    model(o, a, b, est, ed0);
    op = o; rs = a; rt = b;
    st = 0; d0 = 0;
    @(negedge clk);
    while (stall && st < 200) begin
      st++;
      d0 += int'(div0);
      @(negedge clk);
    end
    d0 += int'(div0);
    chk({nm, "_stall"}, 32'(st), 32'(est));
    chk({nm, "_div0"}, 32'(d0), 32'(ed0));
    @(posedge clk); #1;
    op = 8'h00;
  endtask

  task automatic read_hl();
    sb.push_back(hi_m); op = 8'h08;
    @(posedge clk); #1;
    sb.push_back(lo_m); op = 8'h04;
    @(posedge clk); #1;
    op = 8'h00;
  endtask

  initial begin
    logic [7:0] ohs [6];
    logic [7:0] o;
    logic [31:0] a, b;
    ohs = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h02, 8'h01};
    rst = 1'b1; flush = 1'b0; op = 8'h00; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_md", md_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    read_hl();

    run_op(8'h20, 32'hFFFF_FFFE, 32'h0000_0003, "mult"); read_hl();
    run_op(8'h10, 32'hFFFF_FFFE, 32'h0000_0003, "multu"); read_hl();
    run_op(8'h80, 32'hFFFF_FFF9, 32'd2, "div_neg"); read_hl();
    run_op(8'h40, 32'd100, 32'd7, "divu"); read_hl();
    run_op(8'h40, 32'h1234_5678, 32'd0, "divu0"); read_hl();
    run_op(8'h80, 32'h8000_0000, 32'hFFFF_FFFF, "div_min"); read_hl();
    run_op(8'hA1, 32'd77, 32'd5, "prio"); read_hl();

    // HI has priority on a combined mfhi|mflo read.
    sb.push_back(hi_m); op = 8'h0C;
    @(posedge clk); #1; op = 8'h00;

    // Flush on the 10th DIV cycle after preloading HI/LO.
    run_op(8'h02, 32'd5, 32'd0, "mthi");
    run_op(8'h01, 32'd6, 32'd0, "mtlo");
    op = 8'h40; rs = 32'd1000; rt = 32'd3;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", 32'(busy), 32'd1);
    chk("flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; op = 8'h00;
    @(negedge clk);
    chk("flush_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    read_hl();

    // Reset in the middle of a multiply.
    op = 8'h20; rs = 32'd9; rt = 32'd9;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mul_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; op = 8'h00;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    read_hl();
    run_op(8'h20, 32'd3, 32'd4, "mult34"); read_hl();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) o = 8'($urandom) & 8'hF3;
      else o = ohs[$urandom_range(0, 5)];
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(o, a, b, "rand");
      if (i % 3 == 0 || o[7:4] != 4'h0) read_hl();
    end

    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_md_engine.md
EX_MD_ENGINE -- requirements
Module: ex_md_engine

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/HI/LO width (>=4, even).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning multiply busy cycles after issue (>=1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port op  input  8  one-hot command: [7]div [6]divu [5]mult [4]multu [3]mfhi [2]mflo [1]mthi [0]mtlo.
REQ-006 SHALL have port rs_data  input  W  dividend / multiplicand / mthi-mtlo source.
REQ-007 SHALL have port rt_data  input  W  divisor / multiplier.
REQ-008 SHALL have port flush  input  1  abort in-flight operation (exception/branch kill).
REQ-009 SHALL have port md_data  output  W  mfhi/mflo read data.
REQ-010 SHALL have port stall  output  1  hold EX stage; op/rs_data/rt_data held stable by pipeline while high.
REQ-011 SHALL have port busy  output  1  high in MUL or DIV state.
REQ-012 SHALL have port div0  output  1  one-cycle pulse on a divide with rt_data==0.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-014 SHALL decode multiple set op bits by priority div > divu > mult > multu > mthi > mtlo.
REQ-015 SHALL drive md_data combinationally: HI if mfhi, else LO if mflo, else 0; mfhi/mflo do not stall.
REQ-016 SHALL, in IDLE with mthi (mtlo) and no flush, write HI (LO) <= rs_data next edge; no stall.
REQ-017 SHALL assert stall combinationally in IDLE when a mul/div op is present and flush low, and throughout MUL and DIV; stall low in DONE and otherwise.
REQ-018 SHALL, on multiply issue, latch operands, go MUL, count MUL_LAT cycles; on last MUL cycle write {HI,LO} <= 2W-bit product, go DONE.
REQ-019 SHALL compute mult as signed two's-complement and multu as unsigned, full 2W-bit product.
REQ-020 SHALL, on divide issue with rt_data!=0, latch |rs|,|rt| (raw for divu), go DIV, perform restoring radix-2 division one quotient bit per cycle for exactly W cycles, then write HI <= remainder, LO <= quotient, go DONE.
REQ-021 SHALL for signed div negate quotient when operand signs differ and give remainder the dividend's sign; MIN/-1 yields LO=MIN, HI=0.
REQ-022 SHALL, on divide issue with rt_data==0, skip DIV: write HI <= rs_data, LO <= all ones, pulse div0, go DONE (stall 1 cycle).
REQ-023 SHALL ignore op in DONE (same instruction still presented) and return to IDLE next edge.
REQ-024 SHALL total stall cycles: multiply 1+MUL_LAT, divide 1+W, divide-by-zero 1.
REQ-025 SHALL on flush in any state go IDLE next edge, leave HI/LO unchanged, suppress div0, and drive stall low in that cycle; flush beats completion.
REQ-026 SHALL on flush in IDLE suppress mthi/mtlo writes and op issue.
REQ-027 SHALL hold busy equal to (state==MUL or state==DIV).

Reset
REQ-028 SHALL on rst: HI=0, LO=0, state IDLE, counters 0, stall=0 when op idle, busy=0, div0=0, md_data=0; rst overrides flush and any in-flight op.
REQ-029 SHALL treat rst mid-operation as abort with HI/LO cleared; no result written.

Verification (W=32, MUL_LAT=2)
REQ-030 SHALL test mult rs=0xFFFFFFFE, rt=0x00000003 -> stall 3 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL test div rs=0xFFFFFFF9 (-7), rt=2 -> stall 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
REQ-032 SHALL test divu rs=0x12345678, rt=0 -> div0 pulse, stall 1 cycle, HI=0x12345678, LO=0xFFFFFFFF.
REQ-033 SHALL test div rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL test flush on DIV cycle 10 after HI=5, LO=6 preload by mthi/mtlo -> stall low that cycle, IDLE next, mfhi=5, mflo=6.
REQ-035 SHALL test rst asserted during MUL -> next cycle busy=0, HI=LO=0; subsequent mult 3*4 gives LO=12.
